// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory byte bridge: FSM encoding, lane selects,
// the read data returned on an ack timeout, and the latched request layout.
// Latency: n/a (definitions only). Backpressure: n/a.
package dmem_pkg;

  // Bridge sequencing: accept, even byte, odd byte, completion pulse
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic LANE_EVEN = 1'b0;
  localparam logic LANE_ODD  = 1'b1;

  // Read data handed back when the memory never acknowledges
  localparam logic [15:0] TIMEOUT_RDATA = 16'hFFFF;

  // Request fields held for the lifetime of one core access.
  // be0 is only needed at acceptance time, so it is not stored.
  typedef struct packed {
    logic        cmd;
    logic [14:0] waddr;
    logic        be1;
    logic [15:0] wdata;
  } req_t;

  // Byte address of one lane of the addressed 16-bit word
  function automatic logic [15:0] lane_addr(input logic [14:0] waddr, input logic lane);
    return {waddr, lane};
  endfunction

endpackage

// File: rtl/dmem_byte_bridge_if.sv
// Core data-port and byte-memory signals of the bridge bundled into one interface.
// Latency: n/a (wiring only). Backpressure: core holds request until d_mem_rdy, bridge holds mem_req until mem_ack.
// master = core + memory environment side, slave = bridge side.
interface dmem_byte_bridge_if #(
  parameter int ADDR_W = 16
);

  // core data-memory port
  logic        d_mem_assert;
  logic        d_mem_cmd;
  logic [15:0] d_mem_addr;
  logic        d_mem_be0;
  logic        d_mem_be1;
  logic [15:0] d_mem_data_out;
  logic [15:0] d_mem_data_in;
  logic        d_mem_rdy;
  logic        d_mem_err;

  // byte-wide external memory
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  modport master (
    output d_mem_assert, d_mem_cmd, d_mem_addr, d_mem_be0, d_mem_be1, d_mem_data_out,
    input  d_mem_data_in, d_mem_rdy, d_mem_err,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

  modport slave (
    input  d_mem_assert, d_mem_cmd, d_mem_addr, d_mem_be0, d_mem_be1, d_mem_data_out,
    output d_mem_data_in, d_mem_rdy, d_mem_err,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

endinterface

// File: rtl/dmem_timeout_ctr.sv
// Ack watchdog: counts cycles spent waiting for mem_ack, cleared on every bridge state change.
// Latency: expired is combinational, asserted in the cycle whose edge would bring the count to all-ones.
// Backpressure: none; holds its count while en is low.
module dmem_timeout_ctr #(
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] ONE = TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] cnt_q;

  // Firing one step early lets the bridge drop mem_req on the same edge the count reaches all-ones
  assign expired = en && (cnt_q == ~ONE);

  // Wait-cycle counter
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + ONE;
    end
  end

endmodule

// File: rtl/dmem_byte_bridge.sv
// Serves 16-bit core data accesses from a byte-wide req/ack memory, even lane first, then odd lane.
// Latency: assert->rdy inclusive = 2 + (1 + wait cycles) per enabled lane; all outputs registered.
// Backpressure: core holds d_mem_assert until the one-cycle d_mem_rdy; mem_req is held until mem_ack.
// Optional ack watchdog built when DMEM_BRIDGE_TIMEOUT_EN is defined.
module dmem_byte_bridge
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int TIMEOUT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  dmem_byte_bridge_if.slave bus
);

  if (TIMEOUT_W < 1) begin : g_bad_timeout_w
    $error("dmem_byte_bridge: TIMEOUT_W must be at least 1");
  end

  state_t state, state_nxt;

  req_t req_q;
  req_t req_cur;

  logic [15:0] rbuf_q, rbuf_nxt;
  logic        in_xfer;
  logic        timeout;
  logic        accept;

  logic              mem_req_q,   mem_req_nxt;
  logic              mem_we_q,    mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_nxt;
  logic [7:0]        mem_wdata_q, mem_wdata_nxt;
  logic              rdy_q,       rdy_nxt;
  logic [15:0]       data_in_q,   data_in_nxt;

  // Byte lane is selected by the enables, so the address LSB carries no information
  logic unused_addr_lsb;
  assign unused_addr_lsb = bus.d_mem_addr[0];

  assign in_xfer = (state == LO) || (state == HI);
  assign accept  = (state == IDLE) && bus.d_mem_assert;

  // While idle the outgoing transfer is set up straight from the core port; afterwards from the latch
  assign req_cur = (state == IDLE)
                 ? {bus.d_mem_cmd, bus.d_mem_addr[15:1], bus.d_mem_be1, bus.d_mem_data_out}
                 : req_q;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  logic err_q;
  logic to_clr;
  logic to_en;

  assign to_clr = (state_nxt != state);
  assign to_en  = in_xfer && !bus.mem_ack;

  dmem_timeout_ctr #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (to_clr),
    .en      (to_en),
    .expired (timeout)
  );

  // A timeout always lands in DONE, so the flag lines up with the rdy pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
    end
  end

  assign bus.d_mem_err = err_q;
`else
  assign timeout       = 1'b0;
  assign bus.d_mem_err = 1'b0;
`endif

  // State, request latch, read buffer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_q       <= '0;
      rbuf_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdy_q       <= 1'b0;
      data_in_q   <= '0;
    end else begin
      state       <= state_nxt;
      if (accept) begin
        req_q <= req_cur;
      end
      rbuf_q      <= rbuf_nxt;
      mem_req_q   <= mem_req_nxt;
      mem_we_q    <= mem_we_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
      rdy_q       <= rdy_nxt;
      data_in_q   <= data_in_nxt;
    end
  end

  // Next state: walk the enabled lanes, a timeout skips whatever lane is left
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.d_mem_assert) begin
          if (bus.d_mem_be0)      state_nxt = LO;
          else if (bus.d_mem_be1) state_nxt = HI;
          else                    state_nxt = DONE;
        end
      end
      LO: begin
        if (timeout)          state_nxt = DONE;
        else if (bus.mem_ack) state_nxt = req_q.be1 ? HI : DONE;
      end
      HI: begin
        if (timeout || bus.mem_ack) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output values for the coming state, plus read-data assembly (disabled lanes stay 0)
  always_comb begin
    mem_req_nxt   = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = '0;
    mem_wdata_nxt = '0;
    rdy_nxt       = 1'b0;
    data_in_nxt   = '0;
    rbuf_nxt      = rbuf_q;

    if (accept) begin
      rbuf_nxt = '0;
    end else if (state == LO && bus.mem_ack && !req_q.cmd) begin
      rbuf_nxt[7:0] = bus.mem_rdata;
    end else if (state == HI && bus.mem_ack && !req_q.cmd) begin
      rbuf_nxt[15:8] = bus.mem_rdata;
    end

    case (state_nxt)
      LO: begin
        mem_req_nxt   = 1'b1;
        mem_we_nxt    = req_cur.cmd;
        mem_addr_nxt  = ADDR_W'(lane_addr(req_cur.waddr, LANE_EVEN));
        mem_wdata_nxt = req_cur.wdata[7:0];
      end
      HI: begin
        mem_req_nxt   = 1'b1;
        mem_we_nxt    = req_cur.cmd;
        mem_addr_nxt  = ADDR_W'(lane_addr(req_cur.waddr, LANE_ODD));
        mem_wdata_nxt = req_cur.wdata[15:8];
      end
      DONE: begin
        rdy_nxt     = 1'b1;
        data_in_nxt = timeout ? TIMEOUT_RDATA : rbuf_nxt;
      end
      default: begin
      end
    endcase
  end

  assign bus.mem_req       = mem_req_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.d_mem_rdy     = rdy_q;
  assign bus.d_mem_data_in = data_in_q;

endmodule

// File: tb/tb_dmem_byte_bridge.sv
// Bench for dmem_byte_bridge: directed cases then randomized requests against a byte-array memory.
// Expected byte transfers and core responses are queued at issue time and popped by monitors.
module tb_dmem_byte_bridge;

  localparam int TIMEOUT_W = 4;
  localparam int TO_CYC    = (1 << TIMEOUT_W) - 1;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } xfer_t;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          lat;
    int          t0;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  xfer_t xfer_q[$];
  int    wait_q[$];
  rsp_t  rsp_q[$];
  logic [7:0] mem [0:255];

  dmem_byte_bridge_if #(.ADDR_W(16)) bus();

  dmem_byte_bridge #(
    .ADDR_W    (16),
    .TIMEOUT_W (TIMEOUT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one request becomes a list of byte transfers plus one response.
  // A lane with w wait cycles keeps mem_req up for w+1 cycles; with the watchdog a lane
  // needing more than TO_CYC cycles is abandoned after TO_CYC cycles.
  task automatic start_req(input logic cmd, input logic [15:0] addr, input logic be0,
                           input logic be1, input logic [15:0] wd, input int w_lo,
                           input int w_hi, input bit push_rsp);
    rsp_t  r;
    xfer_t x;
    bit    to;
    @(posedge clk);
    #1;
    to     = 1'b0;
    r.data = '0;
    r.lat  = 2;
    r.t0   = cyc;
    if (be0) begin
      x.addr = {addr[15:1], 1'b0}; x.we = cmd; x.wdata = wd[7:0];
      xfer_q.push_back(x);
      wait_q.push_back(w_lo);
      if (TO_EN && w_lo >= TO_CYC) begin
        to = 1'b1;
        r.lat += TO_CYC;
      end else begin
        r.lat += w_lo + 1;
        if (!cmd) r.data[7:0] = mem[{addr[7:1], 1'b0}];
      end
    end
    if (be1 && !to) begin
      x.addr = {addr[15:1], 1'b1}; x.we = cmd; x.wdata = wd[15:8];
      xfer_q.push_back(x);
      wait_q.push_back(w_hi);
      if (TO_EN && w_hi >= TO_CYC) begin
        to = 1'b1;
        r.lat += TO_CYC;
      end else begin
        r.lat += w_hi + 1;
        if (!cmd) r.data[15:8] = mem[{addr[7:1], 1'b1}];
      end
    end
    if (to) r.data = 16'hFFFF;
    r.err = to;
    if (push_rsp) rsp_q.push_back(r);
    bus.d_mem_assert   = 1'b1;
    bus.d_mem_cmd      = cmd;
    bus.d_mem_addr     = addr;
    bus.d_mem_be0      = be0;
    bus.d_mem_be1      = be1;
    bus.d_mem_data_out = wd;
  endtask

  // Wait (bounded) for completion, then release the port and scramble its fields
  task automatic wait_rdy();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (bus.d_mem_rdy) got = 1'b1;
    end
    check("rdy_seen", 32'(got), 32'd1);
    bus.d_mem_assert   = 1'b0;
    bus.d_mem_cmd      = 1'($urandom_range(0, 1));
    bus.d_mem_addr     = 16'($urandom);
    bus.d_mem_be0      = 1'($urandom_range(0, 1));
    bus.d_mem_be1      = 1'($urandom_range(0, 1));
    bus.d_mem_data_out = 16'($urandom);
  endtask

  // Memory responder: checks each new transfer, acks after its planned wait cycles,
  // and throws stray acks / garbage read data whenever no transfer is being served.
  initial begin
    bit    busy;
    int    wleft;
    xfer_t x;
    busy  = 1'b0;
    wleft = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'($urandom);
      if (rst || bus.mem_req !== 1'b1) begin
        busy        = 1'b0;
        bus.mem_ack = ($urandom_range(0, 3) == 0);
      end else begin
        if (!busy) begin
          busy = 1'b1;
          if (wait_q.size() == 0) begin
            check("wait_plan_present", 32'd0, 32'd1);
            wleft = 0;
          end else begin
            wleft = wait_q.pop_front();
          end
          if (xfer_q.size() == 0) begin
            check("spurious_mem_req", 32'd1, 32'd0);
          end else begin
            x = xfer_q.pop_front();
            check("mem_addr",  32'(bus.mem_addr),  32'(x.addr));
            check("mem_we",    32'(bus.mem_we),    32'(x.we));
            if (x.we) check("mem_wdata", 32'(bus.mem_wdata), 32'(x.wdata));
          end
        end
        if (wleft == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem[bus.mem_addr[7:0]];
          if (bus.mem_we) mem[bus.mem_addr[7:0]] = bus.mem_wdata;
          busy = 1'b0;
        end else begin
          wleft--;
        end
      end
    end
  end

  // Completion monitor
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.d_mem_rdy === 1'b1) begin
        if (rsp_q.size() == 0) begin
          check("spurious_rdy", 32'd1, 32'd0);
        end else begin
          r = rsp_q.pop_front();
          check("data_in", 32'(bus.d_mem_data_in), 32'(r.data));
          check("d_mem_err", 32'(bus.d_mem_err), 32'(r.err));
          check("latency", 32'(cyc - r.t0 + 1), 32'(r.lat));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "tb_dmem_byte_bridge stuck");
  end

  initial begin
    bit found;
    logic [15:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rst = 1'b1;
    bus.d_mem_assert   = 1'b0;
    bus.d_mem_cmd      = 1'b0;
    bus.d_mem_addr     = 16'h0000;
    bus.d_mem_be0      = 1'b0;
    bus.d_mem_be1      = 1'b0;
    bus.d_mem_data_out = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mem_side",  32'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'd0);
    check("reset_core_side", 32'({bus.d_mem_rdy, bus.d_mem_err, bus.d_mem_data_in}), 32'd0);
    rst = 1'b0;

    // word read, zero wait, known bytes
    mem[8'hA0] = 8'h34;
    mem[8'hA1] = 8'h12;
    start_req(1'b0, 16'h00A0, 1'b1, 1'b1, 16'h5A5A, 0, 0, 1'b1);
    wait_rdy();
    // odd-lane byte write
    start_req(1'b1, 16'h00A3, 1'b0, 1'b1, 16'hC0DE, 0, 0, 1'b1);
    wait_rdy();
    // word write, two wait cycles per lane
    start_req(1'b1, 16'h0040, 1'b1, 1'b1, 16'hBEEF, 2, 2, 1'b1);
    wait_rdy();
    // no lanes enabled
    start_req(1'b0, 16'h0011, 1'b0, 1'b0, 16'h0000, 0, 0, 1'b1);
    wait_rdy();
    // read back the bytes just written
    start_req(1'b0, 16'h0040, 1'b1, 1'b1, 16'h0000, 1, 0, 1'b1);
    wait_rdy();

    // reset while the odd lane waits for its ack
    start_req(1'b0, 16'h0052, 1'b1, 1'b1, 16'h0000, 0, 1000, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_addr[0]) found = 1'b1;
    end
    check("reached_odd_lane", 32'(found), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_mem_side",  32'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'd0);
    check("abort_core_side", 32'({bus.d_mem_rdy, bus.d_mem_err, bus.d_mem_data_in}), 32'd0);
    rst = 1'b0;
    bus.d_mem_assert = 1'b0;
    repeat (3) @(negedge clk);
    start_req(1'b0, 16'h0052, 1'b1, 1'b1, 16'h0000, 0, 1, 1'b1);
    wait_rdy();

    // memory that is very late (or never answers when the watchdog is built)
    if (TO_EN) begin
      start_req(1'b0, 16'h0066, 1'b1, 1'b1, 16'h0000, 1000, 0, 1'b1);
      wait_rdy();
      start_req(1'b0, 16'h0068, 1'b1, 1'b1, 16'h0000, 0, 1000, 1'b1);
      wait_rdy();
    end else begin
      start_req(1'b0, 16'h0064, 1'b1, 1'b0, 16'h0000, 40, 0, 1'b1);
      wait_rdy();
    end

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      a = 16'($urandom_range(0, 255));
      start_req(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'($urandom), (($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 3))),
                int'($urandom_range(0, 3)), 1'b1);
      wait_rdy();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(negedge clk);
    check("rsp_queue_drained",  32'(rsp_q.size()),  32'd0);
    check("xfer_queue_drained", 32'(xfer_q.size()), 32'd0);
    check("wait_queue_drained", 32'(wait_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
